// File: rtl/arith_pkg.sv
// Shared arithmetic constants and a golden subtract function, used by the
// half subtractor's internal checks and by its bench scoreboard.
package arith_pkg;

  localparam int MAX_WIDTH = 64;

  // Returns {borrow, diff}. Diff is masked to `width` bits and zero-extended.
  function automatic logic [MAX_WIDTH:0] ref_sub(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input int unsigned          width
  );
    logic [MAX_WIDTH-1:0] mask;
    logic [MAX_WIDTH-1:0] am;
    logic [MAX_WIDTH-1:0] bm;
    mask = {MAX_WIDTH{1'b1}} >> (MAX_WIDTH - width);
    am   = a & mask;
    bm   = b & mask;
    return {am < bm, (am - bm) & mask};
  endfunction

endpackage

// File: rtl/sub_bit_cell.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow-out.
module sub_bit_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/half_subtractor.sv
// Registered WIDTH-bit subtractor: one-cycle latency diff = a - b and
// borrow = (a < b), with a one-cycle out_valid pulse per accepted pair.
module half_subtractor
  import arith_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic             borrow,
  output logic [WIDTH-1:0] diff,
  output logic             out_valid
);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $fatal(1, "half_subtractor: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end

  logic [WIDTH:0]   bchain;
  logic [WIDTH-1:0] diff_d;
  logic             borrow_d;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             out_valid_q;

  assign bchain[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    sub_bit_cell u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .bin  (bchain[i]),
      .d    (diff_d[i]),
      .bout (bchain[i+1])
    );
  end

  assign borrow_d = bchain[WIDTH];

  // Results only update on accepted operands; out_valid is a pure pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q      <= '0;
      borrow_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        diff_q   <= diff_d;
        borrow_q <= borrow_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && in_valid) begin
      assert (ref_sub(MAX_WIDTH'(a), MAX_WIDTH'(b), WIDTH) == {borrow_d, MAX_WIDTH'(diff_d)})
        else $error("half_subtractor: ripple chain disagrees with ref_sub");
    end
  end

  assign diff      = diff_q;
  assign borrow    = borrow_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_half_subtractor.sv
// Directed and randomised checks of half_subtractor at WIDTH = 1, 8 and 16.
module tb_half_subtractor;
  import arith_pkg::*;

  logic clk;
  logic rst_n;

  logic       a1, b1, v1, bo1, ov1;
  logic [0:0] d1;
  logic [7:0] a8, b8, d8;
  logic       v8, bo8, ov8;
  logic [15:0] a16, b16, d16;
  logic        v16, bo16, ov16;

  int n_cmp  = 0;
  int n_fail = 0;

  half_subtractor #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(v1),
    .borrow(bo1), .diff(d1), .out_valid(ov1)
  );
  half_subtractor #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .a(a8), .b(b8), .in_valid(v8),
    .borrow(bo8), .diff(d8), .out_valid(ov8)
  );
  half_subtractor #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .a(a16), .b(b16), .in_valid(v16),
    .borrow(bo16), .diff(d16), .out_valid(ov16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0]  va  [4];
    logic [1:0]  vexp[4];
    logic [7:0]  a8v [5];
    logic [7:0]  b8v [5];
    logic [8:0]  e8v [5];
    logic [64:0] r;
    logic [16:0] exp16;
    int          seen16;

    rst_n = 1'b0;
    a1 = 0; b1 = 0; v1 = 0;
    a8 = '0; b8 = '0; v8 = 0;
    a16 = '0; b16 = '0; v16 = 0;
    #2;
    chk("reset_w1",  {15'd0, ov1, bo1, d1}, 18'd0);
    chk("reset_w8",  {8'd0, ov8, bo8, d8}, 18'd0);
    chk("reset_w16", {ov16, bo16, d16}, 18'd0);
    step();
    #2 rst_n = 1'b1;

    // WIDTH=1 truth table: a/b vector {a,b}, expected {borrow,diff}
    va[0] = 2'b00; vexp[0] = 2'b00;
    va[1] = 2'b01; vexp[1] = 2'b11;
    va[2] = 2'b10; vexp[2] = 2'b01;
    va[3] = 2'b11; vexp[3] = 2'b00;
    step();
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = va[i]; v1 = 1'b1;
      step();
      chk($sformatf("w1_tt%0d", i), {15'd0, ov1, bo1, d1}, {15'd0, 1'b1, vexp[i]});
    end

    // in_valid gating: capture 0-1, then hold 1/1 with in_valid low.
    a1 = 0; b1 = 1; v1 = 1;
    step();
    chk("w1_gate_cap", {15'd0, ov1, bo1, d1}, {15'd0, 3'b111});
    a1 = 1; b1 = 1; v1 = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("w1_gate_hold%0d", i), {15'd0, ov1, bo1, d1}, {15'd0, 3'b011});
    end

    // Async reset between edges; the operand pending at assertion is lost.
    a1 = 0; b1 = 1; v1 = 1;
    step();
    chk("w1_pre_rst", {15'd0, ov1, bo1, d1}, {15'd0, 3'b111});
    a1 = 1; b1 = 0; v1 = 1;
    #2 rst_n = 1'b0;
    #1;
    chk("w1_async_rst", {15'd0, ov1, bo1, d1}, 18'd0);
    step();
    chk("w1_rst_held", {15'd0, ov1, bo1, d1}, 18'd0);
    v1 = 0;
    #2 rst_n = 1'b1;
    step();
    chk("w1_post_rel_idle", {15'd0, ov1, bo1, d1}, 18'd0);
    a1 = 1; b1 = 0; v1 = 1;
    step();
    chk("w1_first_after_rel", {15'd0, ov1, bo1, d1}, {15'd0, 3'b101});
    v1 = 0;

    // WIDTH=8 boundaries and borrow ripple, back-to-back; expected {borrow,diff}
    a8v[0] = 8'h00; b8v[0] = 8'hFF; e8v[0] = 9'h101;
    a8v[1] = 8'hFF; b8v[1] = 8'h00; e8v[1] = 9'h0FF;
    a8v[2] = 8'h5A; b8v[2] = 8'h5A; e8v[2] = 9'h000;
    a8v[3] = 8'h80; b8v[3] = 8'h01; e8v[3] = 9'h07F;
    a8v[4] = 8'h10; b8v[4] = 8'h20; e8v[4] = 9'h1F0;
    for (int i = 0; i < 5; i++) begin
      a8 = a8v[i]; b8 = b8v[i]; v8 = 1'b1;
      step();
      chk($sformatf("w8_vec%0d", i), {8'd0, ov8, bo8, d8}, {8'd0, 1'b1, e8v[i]});
    end
    v8 = 0;
    step();
    chk("w8_idle", {8'd0, ov8, bo8, d8}, {8'd0, 1'b0, e8v[4]});

    // WIDTH=16 random stream at full throughput
    exp16  = '0;
    seen16 = 0;
    for (int i = 0; i <= 1000; i++) begin
      if (i < 1000) begin
        a16 = 16'($urandom); b16 = 16'($urandom); v16 = 1'b1;
      end else begin
        v16 = 1'b0;
      end
      step();
      if (ov16) seen16++;
      if (i < 1000) begin
        r = ref_sub(64'(a16), 64'(b16), 16);
        exp16 = {r[64], r[15:0]};
      end
      chk($sformatf("w16_rand%0d", i), {ov16, bo16, d16}, {(i < 1000), exp16});
    end
    chk("w16_result_count", 18'(seen16), 18'd1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
